// File: rtl/uart_defs.sv
// rtl/uart_defs.sv - shared UART state encodings, oversampling constants and vote helper
package uart_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// rtl/uart_rx_engine_if.sv - receive holding register bus between engine and peripheral block
interface uart_rx_engine_if;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_irq;

    modport master (
        output rd_ack,
        input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_irq
    );

    modport slave (
        input  rd_ack,
        output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_irq
    );
endinterface

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick divider, held at zero while not running
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic sysclk,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (!run || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - 8N1 receiver with majority-vote sampling and a single holding register
module uart_rx_engine
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic           sysclk,
    input  logic           reset,
    input  logic           rx_in,
    uart_rx_engine_if.slave bus
);
    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam logic [3:0] S_LO  = 4'(MID_SAMPLE - 1);
    localparam logic [3:0] S_MID = 4'(MID_SAMPLE);
    localparam logic [3:0] S_HI  = 4'(MID_SAMPLE + 1);

    logic        sync1, rx_sync, rx_prev;
    logic        tick, run;
    uart_state_t state;
    logic [3:0]  s;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        smp_a, smp_b;
    logic        brk_ok;
    logic        bit_val, decide, accept, ferr_set;

    logic [7:0]  data_q;
    logic        valid_q, overrun_q, ferr_q;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx_in;
            rx_sync <= sync1;
            rx_prev <= rx_sync;
        end
    end

    assign run = (state != IDLE);

    uart_baud_tick #(.DIV(DIV)) u_baud_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .run    (run),
        .tick   (tick)
    );

    // Third vote is the live synchronised line on the s==9 tick itself.
    assign bit_val  = majority3(smp_a, smp_b, rx_sync);
    assign decide   = tick && (s == S_HI);
    assign accept   = (state == STOP) && decide && bit_val;
    assign ferr_set = (state == STOP) && decide && !bit_val;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            s       <= 4'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
            smp_a   <= 1'b1;
            smp_b   <= 1'b1;
            brk_ok  <= 1'b0;
        end else begin
            if (tick) begin
                s <= s + 1'b1;
                if (s == S_LO)  smp_a <= rx_sync;
                if (s == S_MID) smp_b <= rx_sync;
            end
            case (state)
                IDLE: begin
                    s <= 4'd0;
                    if (rx_prev && !rx_sync) state <= START;
                end
                START: begin
                    if (decide) begin
                        if (!bit_val) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        shreg <= {bit_val, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= IDLE;
                        end else begin
                            state  <= BREAK;
                            brk_ok <= 1'b0;
                        end
                    end
                end
                BREAK: begin
                    // Leave only after a whole tick period with the line continuously high.
                    if (tick) begin
                        if (brk_ok && rx_sync) state <= IDLE;
                        brk_ok <= 1'b1;
                    end else if (!rx_sync) begin
                        brk_ok <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (accept && (!valid_q || bus.rd_ack)) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
            end else if (bus.rd_ack) begin
                valid_q <= 1'b0;
            end

            if (accept && valid_q && !bus.rd_ack) overrun_q <= 1'b1;
            else if (bus.rd_ack)                  overrun_q <= 1'b0;

            if (ferr_set)         ferr_q <= 1'b1;
            else if (bus.rd_ack)  ferr_q <= 1'b0;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_overrun   = overrun_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_irq       = valid_q | overrun_q | ferr_q;
endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed vector bench for uart_rx_engine at 160 sysclk per bit
module tb_uart_rx_engine;

    localparam int BIT = 160;

    logic sysclk;
    logic reset;
    logic rx_in;

    uart_rx_engine_if bus();

    uart_rx_engine #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (10_000),
        .OVERSAMPLE (16)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .rx_in  (rx_in),
        .bus    (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int drop_cnt = 0;
    logic watch = 1'b0;
    logic v_d = 1'b0;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (bus.rx_valid && !v_d) rise_cyc = cyc;
        v_d = bus.rx_valid;
        if (watch && !bus.rx_valid) drop_cnt = drop_cnt + 1;
    end

    typedef struct {
        logic       ack;
        logic [7:0] d;
        logic       stop;
        logic [7:0] e_data;
        logic       e_v;
        logic       e_o;
        logic       e_f;
        logic       e_irq;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        else             passed = passed + 1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                             input logic o, input logic f, input logic irq);
        chk($sformatf("%s.rx_data", tag),      32'(bus.rx_data),      32'(d));
        chk($sformatf("%s.rx_valid", tag),     32'(bus.rx_valid),     32'(v));
        chk($sformatf("%s.rx_overrun", tag),   32'(bus.rx_overrun),   32'(o));
        chk($sformatf("%s.rx_frame_err", tag), 32'(bus.rx_frame_err), 32'(f));
        chk($sformatf("%s.rx_irq", tag),       32'(bus.rx_irq),       32'(irq));
    endtask

    task automatic pulse_ack();
        @(posedge sysclk); #1;
        bus.rd_ack = 1'b1;
        @(posedge sysclk); #1;
        bus.rd_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        @(negedge sysclk);
    endtask

    // Drives a frame for len cycles; a short len abandons it mid-frame.
    task automatic send_byte(input logic [7:0] d, input logic stop, input int spike, input int len);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        @(posedge sysclk); #1;
        start_cyc = cyc;
        for (int c = 0; c < len; c++) begin
            rx_in = fr[c / BIT];
            if (c == spike) rx_in = ~rx_in;
            @(posedge sysclk); #1;
        end
        if (len < 10 * BIT) return;
        if (!stop) begin
            rx_in = 1'b0;
            repeat (2 * BIT) @(posedge sysclk);
            #1;
        end
        rx_in = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        rx_in       = 1'b1;
        bus.rd_ack  = 1'b0;

        vt[0] = '{1'b0, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 8'h11, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{1'b0, 8'h22, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 8'h55, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[7] = '{1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};

        #12;
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge sysclk);
        reset = 1'b1;
        idle(5);

        for (int i = 0; i < 8; i++) begin
            if (vt[i].ack) pulse_ack();
            send_byte(vt[i].d, vt[i].stop, -1, 10 * BIT);
            idle(60);
            check_all($sformatf("vec%0d", i), vt[i].e_data, vt[i].e_v, vt[i].e_o, vt[i].e_f, vt[i].e_irq);
        end

        pulse_ack();
        @(negedge sysclk);
        check_all("ack_clear", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        rise_cyc = 0;
        send_byte(8'hA5, 1'b1, -1, 10 * BIT);
        idle(60);
        total = total + 1;
        if ((rise_cyc - start_cyc) >= 1510 && (rise_cyc - start_cyc) <= 1560)
            passed = passed + 1;
        else
            $display("FAIL latency actual=%0d cycles required=1510..1560", rise_cyc - start_cyc);
        check_all("latency", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);

        drop_cnt = 0;
        watch    = 1'b1;
        fork
            send_byte(8'h5A, 1'b1, -1, 10 * BIT);
            begin
                @(posedge sysclk);
                repeat (1542) @(posedge sysclk);
                #1 bus.rd_ack = 1'b1;
                @(posedge sysclk);
                #1 bus.rd_ack = 1'b0;
            end
        join
        idle(60);
        watch = 1'b0;
        check_all("same_cycle_ack", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("same_cycle_ack.valid_drops", 32'(drop_cnt), 32'd0);

        pulse_ack();
        send_byte(8'hFF, 1'b1, 9 * 80 + 10, 10 * BIT);
        idle(60);
        check_all("spike", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

        pulse_ack();
        @(posedge sysclk); #1;
        rx_in = 1'b0;
        repeat (40) @(posedge sysclk);
        #1 rx_in = 1'b1;
        idle(200);
        check_all("glitch", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        send_byte(8'h33, 1'b1, -1, 10 * BIT);
        idle(60);
        check_all("pre_reset", 8'h33, 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h77, 1'b1, -1, 600);
        @(negedge sysclk);
        reset = 1'b0;
        #1;
        check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_in = 1'b1;
        repeat (5) @(negedge sysclk);
        reset = 1'b1;
        idle(50);
        check_all("post_reset_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h81, 1'b1, -1, 10 * BIT);
        idle(60);
        check_all("post_reset", 8'h81, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
